vinc_access_ctrl: RTL and testbench

- Arbitrates the single read port (a) and single write port (c) of the vector inc register file between two requesters.
  - Requester 0: scalar control-register move unit (ctc/cfc).
  - Requester 1: vector memory unit (stride/post-increment update).
- Tracks the one-cycle registered read, forwards same-cycle write data over the RAM's old-data mixed-port behaviour, and forces inc0 reads to zero.
- Sits between the requesters and vregfile_inc.

---
 rtl/vinc_pkg.sv | 12 +
 rtl/vinc_rr_arb2.sv | 32 +++
 rtl/vinc_access_ctrl.sv | 121 ++++++++++++
 tb/tb_vinc_access_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/vinc_pkg.sv
// Shared constants for the vector inc register-file access controller.
// Holds the requester ids and the default register-file geometry.
package vinc_pkg;

    localparam int VINC_WIDTH       = 32;
    localparam int VINC_NUMREGS     = 8;
    localparam int VINC_LOG2NUMREGS = 3;

    localparam logic VINC_REQ_CTRL = 1'b0;
    localparam logic VINC_REQ_MEM  = 1'b1;

endpackage

// File: rtl/vinc_rr_arb2.sv
// Two-way round-robin arbiter.
// The pointer only moves when both requesters compete, and then passes to the loser.
module vinc_rr_arb2
    import vinc_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (ptr == VINC_REQ_CTRL) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr <= VINC_REQ_CTRL;
        end else if (req == 2'b11) begin
            ptr <= ~ptr;
        end
    end

endmodule

// File: rtl/vinc_access_ctrl.sv
// Shares the inc register file read port (a) and write port (c) between the control and memory units.
// It also tracks the one-cycle read, forwards same-cycle writes over the RAM's old data, and forces inc0 reads to zero.
module vinc_access_ctrl
    import vinc_pkg::*;
#(
    parameter int WIDTH       = VINC_WIDTH,
    parameter int NUMREGS     = VINC_NUMREGS,
    parameter int LOG2NUMREGS = VINC_LOG2NUMREGS
) (
    input  logic                   clk,
    input  logic                   resetn,

    input  logic [1:0]             rd_req,
    input  logic [LOG2NUMREGS-1:0] rd_reg0,
    input  logic [LOG2NUMREGS-1:0] rd_reg1,
    output logic [1:0]             rd_gnt,
    output logic                   rd_valid,
    output logic                   rd_id,
    output logic [WIDTH-1:0]       rd_data,

    input  logic [1:0]             wr_req,
    input  logic [LOG2NUMREGS-1:0] wr_reg0,
    input  logic [LOG2NUMREGS-1:0] wr_reg1,
    input  logic [WIDTH-1:0]       wr_data0,
    input  logic [WIDTH-1:0]       wr_data1,
    output logic [1:0]             wr_gnt,

    output logic [LOG2NUMREGS-1:0] a_reg,
    output logic                   a_en,
    input  logic [WIDTH-1:0]       a_readdataout,

    output logic [LOG2NUMREGS-1:0] c_reg,
    output logic [WIDTH-1:0]       c_writedatain,
    output logic                   c_we
);

    logic [LOG2NUMREGS-1:0] rd_idx;
    logic [LOG2NUMREGS-1:0] wr_idx;
    logic [WIDTH-1:0]       wr_sel_data;
    logic                   fwd_hit;

    logic                   zero_flag;
    logic                   bypass_valid;
    logic [WIDTH-1:0]       bypass_data;

    vinc_rr_arb2 u_rd_arb (
        .clk    (clk),
        .resetn (resetn),
        .req    (rd_req),
        .gnt    (rd_gnt)
    );

    vinc_rr_arb2 u_wr_arb (
        .clk    (clk),
        .resetn (resetn),
        .req    (wr_req),
        .gnt    (wr_gnt)
    );

    always_comb begin
        rd_idx      = '0;
        wr_idx      = '0;
        wr_sel_data = '0;
        if (rd_gnt[1]) begin
            rd_idx = rd_reg1;
        end else if (rd_gnt[0]) begin
            rd_idx = rd_reg0;
        end
        if (wr_gnt[1]) begin
            wr_idx      = wr_reg1;
            wr_sel_data = wr_data1;
        end else if (wr_gnt[0]) begin
            wr_idx      = wr_reg0;
            wr_sel_data = wr_data0;
        end
    end

    assign a_en          = |rd_gnt;
    assign a_reg         = rd_idx;
    assign c_reg         = wr_idx;
    assign c_writedatain = wr_sel_data;
    // inc0 is hardwired to zero, so a write to it is granted but never reaches the RAM.
    assign c_we          = (|wr_gnt) && (wr_idx != '0) && (32'(wr_idx) < NUMREGS);

    // The RAM returns old data on a same-address read/write collision; this flags that case.
    assign fwd_hit = a_en && c_we && (wr_idx == rd_idx);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_valid     <= 1'b0;
            rd_id        <= VINC_REQ_CTRL;
            zero_flag    <= 1'b0;
            bypass_valid <= 1'b0;
            bypass_data  <= '0;
        end else begin
            rd_valid     <= a_en;
            zero_flag    <= a_en && (rd_idx == '0);
            bypass_valid <= fwd_hit;
            if (a_en) begin
                rd_id <= rd_gnt[1] ? VINC_REQ_MEM : VINC_REQ_CTRL;
            end
            if (fwd_hit) begin
                bypass_data <= wr_sel_data;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_valid) begin
            if (zero_flag) begin
                rd_data = '0;
            end else if (bypass_valid) begin
                rd_data = bypass_data;
            end else begin
                rd_data = a_readdataout;
            end
        end
    end

endmodule

// File: tb/tb_vinc_access_ctrl.sv
// Directed bench for vinc_access_ctrl: it models the arbiters and register contents on its own.
// Expected reads are queued when a grant is predicted and compared one cycle later.
module tb_vinc_access_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  rd_req, wr_req;
    logic [2:0]  rd_reg0, rd_reg1, wr_reg0, wr_reg1;
    logic [31:0] wr_data0, wr_data1;
    logic [1:0]  rd_gnt, wr_gnt;
    logic        rd_valid, rd_id;
    logic [31:0] rd_data;
    logic [2:0]  a_reg, c_reg;
    logic        a_en, c_we;
    logic [31:0] a_readdataout, c_writedatain;

    always #5 clk = ~clk;

    vinc_access_ctrl dut (
        .clk           (clk),
        .resetn        (resetn),
        .rd_req        (rd_req),
        .rd_reg0       (rd_reg0),
        .rd_reg1       (rd_reg1),
        .rd_gnt        (rd_gnt),
        .rd_valid      (rd_valid),
        .rd_id         (rd_id),
        .rd_data       (rd_data),
        .wr_req        (wr_req),
        .wr_reg0       (wr_reg0),
        .wr_reg1       (wr_reg1),
        .wr_data0      (wr_data0),
        .wr_data1      (wr_data1),
        .wr_gnt        (wr_gnt),
        .a_reg         (a_reg),
        .a_en          (a_en),
        .a_readdataout (a_readdataout),
        .c_reg         (c_reg),
        .c_writedatain (c_writedatain),
        .c_we          (c_we)
    );

    // Register-file stand-in: registered read with old-data behaviour on collisions.
    logic [31:0] rf [8];
    logic [31:0] rf_q;
    always @(posedge clk) begin
        if (a_en) rf_q <= rf[a_reg];
        if (c_we) rf[c_reg] <= c_writedatain;
    end
    assign a_readdataout = rf_q;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] shadow [8];
    logic        rd_ptr_m, wr_ptr_m;
    int          errors = 0;
    int          checks = 0;

    function automatic logic [1:0] mgnt(input logic [1:0] rq, input logic p);
        if (rq == 2'b11) return p ? 2'b10 : 2'b01;
        return rq;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step(input logic [1:0] rq, input logic [2:0] r0, input logic [2:0] r1,
                        input logic [1:0] wq, input logic [2:0] w0, input logic [31:0] d0,
                        input logic [2:0] w1, input logic [31:0] d1);
        logic [1:0]  eg_r, eg_w;
        logic [2:0]  ridx, widx;
        logic [31:0] wdat, edat;
        exp_t        e;
        rd_req = rq; rd_reg0 = r0; rd_reg1 = r1;
        wr_req = wq; wr_reg0 = w0; wr_reg1 = w1; wr_data0 = d0; wr_data1 = d1;
        #4;
        eg_r = mgnt(rq, rd_ptr_m);
        eg_w = mgnt(wq, wr_ptr_m);
        ridx = eg_r[1] ? r1 : (eg_r[0] ? r0 : 3'd0);
        widx = eg_w[1] ? w1 : (eg_w[0] ? w0 : 3'd0);
        wdat = eg_w[1] ? d1 : (eg_w[0] ? d0 : 32'd0);
        chk("rd_gnt", 32'(rd_gnt), 32'(eg_r));
        chk("a_en", 32'(a_en), 32'(|eg_r));
        chk("a_reg", 32'(a_reg), 32'(ridx));
        chk("wr_gnt", 32'(wr_gnt), 32'(eg_w));
        chk("c_we", 32'(c_we), 32'((|eg_w) && widx != 3'd0));
        chk("c_reg", 32'(c_reg), 32'(widx));
        chk("c_writedatain", c_writedatain, wdat);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rd_valid", 32'(rd_valid), 32'd1);
            chk("rd_id", 32'(rd_id), 32'(e.id));
            chk("rd_data", rd_data, e.data);
        end else begin
            chk("rd_valid_idle", 32'(rd_valid), 32'd0);
            chk("rd_data_idle", rd_data, 32'd0);
        end
        if (|eg_r) begin
            if (ridx == 3'd0) edat = 32'd0;
            else if ((|eg_w) && widx == ridx) edat = wdat;
            else edat = shadow[ridx];
            e.id = eg_r[1];
            e.data = edat;
            exp_q.push_back(e);
        end
        if (rq == 2'b11) rd_ptr_m = ~rd_ptr_m;
        if (wq == 2'b11) wr_ptr_m = ~wr_ptr_m;
        if ((|eg_w) && widx != 3'd0) shadow[widx] = wdat;
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        rd_req = 2'b00; rd_reg0 = 3'd0; rd_reg1 = 3'd0;
        wr_req = 2'b00; wr_reg0 = 3'd0; wr_reg1 = 3'd0;
        wr_data0 = 32'd0; wr_data1 = 32'd0;
        rd_ptr_m = 1'b0; wr_ptr_m = 1'b0;
        for (int i = 0; i < 8; i++) shadow[i] = 32'd0;
        #3;
        chk("reset_rd_valid", 32'(rd_valid), 32'd0);
        chk("reset_rd_id", 32'(rd_id), 32'd0);
        chk("reset_rd_gnt", 32'(rd_gnt), 32'd0);
        chk("reset_c_we", 32'(c_we), 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // preload: contended write, then the loser, then a third register
        step(2'b00, 3'd0, 3'd0, 2'b11, 3'd3, 32'h1234, 3'd5, 32'h5555);
        step(2'b00, 3'd0, 3'd0, 2'b10, 3'd0, 32'h0,    3'd5, 32'h5555);
        step(2'b00, 3'd0, 3'd0, 2'b01, 3'd2, 32'h2222, 3'd0, 32'h0);
        // single read of r3
        step(2'b01, 3'd3, 3'd0, 2'b00, 3'd0, 32'h0, 3'd0, 32'h0);
        // contended reads held four cycles
        for (int k = 0; k < 4; k++)
            step(2'b11, 3'd3, 3'd5, 2'b00, 3'd0, 32'h0, 3'd0, 32'h0);
        step(2'b00, 3'd0, 3'd0, 2'b00, 3'd0, 32'h0, 3'd0, 32'h0);
        // same-cycle write forwarding, then RAM read of the new value
        step(2'b01, 3'd5, 3'd0, 2'b10, 3'd0, 32'h0, 3'd5, 32'hAAAA);
        step(2'b10, 3'd0, 3'd5, 2'b00, 3'd0, 32'h0, 3'd0, 32'h0);
        // inc0: write suppressed, reads forced to zero
        step(2'b00, 3'd0, 3'd0, 2'b01, 3'd0, 32'hFFFF, 3'd0, 32'h0);
        step(2'b01, 3'd0, 3'd0, 2'b00, 3'd0, 32'h0, 3'd0, 32'h0);
        step(2'b10, 3'd0, 3'd0, 2'b01, 3'd0, 32'hFFFF, 3'd0, 32'h0);
        // write in the cycle after a read grant must not leak into the result
        step(2'b01, 3'd2, 3'd0, 2'b00, 3'd0, 32'h0, 3'd0, 32'h0);
        step(2'b00, 3'd0, 3'd0, 2'b10, 3'd0, 32'h0, 3'd2, 32'h77);
        step(2'b10, 3'd0, 3'd2, 2'b00, 3'd0, 32'h0, 3'd0, 32'h0);
        // contended read+write, then reset while the read is outstanding
        step(2'b11, 3'd3, 3'd5, 2'b11, 3'd6, 32'h6666, 3'd7, 32'h7777);
        chk("pre_reset_rd_valid", 32'(rd_valid), 32'd1);
        rd_req = 2'b00; wr_req = 2'b00;
        resetn = 1'b0;
        #1;
        chk("async_reset_rd_valid", 32'(rd_valid), 32'd0);
        chk("async_reset_rd_data", rd_data, 32'd0);
        chk("async_reset_rd_id", 32'(rd_id), 32'd0);
        exp_q.delete();
        rd_ptr_m = 1'b0;
        wr_ptr_m = 1'b0;
        @(posedge clk);
        #1;
        chk("held_reset_rd_valid", 32'(rd_valid), 32'd0);
        resetn = 1'b1;
        step(2'b11, 3'd3, 3'd5, 2'b11, 3'd6, 32'h6060, 3'd7, 32'h7070);
        step(2'b00, 3'd0, 3'd0, 2'b00, 3'd0, 32'h0, 3'd0, 32'h0);
        step(2'b00, 3'd0, 3'd0, 2'b00, 3'd0, 32'h0, 3'd0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
